fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer. It keeps the fetch PC, sends one
// request at a time to instruction memory, buffers the returned instruction
// for the consumer, and handles branch/jump redirects at any point in that
// sequence.
//
// Ports
//   clk                 clock; all state changes on the rising edge
//   rst                 asynchronous, active-low reset (0 = reset)
//   stall_in            consumer cannot take the buffered instruction
//   redirect_valid_in   redirect request
//   redirect_pc_in      redirect target (bits [1:0] are ignored)
//   mem_req_valid_out   memory request valid
//   mem_req_addr_out    memory request address
//   mem_req_ready_in    memory accepts the request
//   mem_rsp_valid_in    memory response valid
//   mem_rsp_data_in     memory response instruction
//   inst_valid_out      inst_out / inst_pc_out valid
//   inst_out            fetched instruction
//   inst_pc_out         PC of inst_out
//   state_dbg           current FSM state (BOOT=0, REQ=1, WAIT=2, HOLD=3)
//
// Handshakes
//   Memory request: a request transfers on a rising edge where
//   mem_req_valid_out && mem_req_ready_in. Once raised, valid stays high and
//   the address stays stable until the transfer; only a redirect may change
//   the address of a not-yet-accepted request. The response side has no
//   ready: mem_rsp_valid_in is only looked at while a request is
//   outstanding. Instruction output: inst_valid_out is held with stable
//   data until a cycle with stall_in=0 (stall_in acts as the inverted
//   ready), or until a redirect discards the buffered instruction.
module fetch_ctrl #(
  parameter int                 ARCH_LEN  = 32,
  parameter int                 INST_LEN  = 32,
  parameter logic [ARCH_LEN-1:0] BOOT_ADDR = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_in,
  input  logic                redirect_valid_in,
  input  logic [ARCH_LEN-1:0] redirect_pc_in,
  output logic                mem_req_valid_out,
  output logic [ARCH_LEN-1:0] mem_req_addr_out,
  input  logic                mem_req_ready_in,
  input  logic                mem_rsp_valid_in,
  input  logic [INST_LEN-1:0] mem_rsp_data_in,
  output logic                inst_valid_out,
  output logic [INST_LEN-1:0] inst_out,
  output logic [ARCH_LEN-1:0] inst_pc_out,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [ARCH_LEN-1:0] PC_STEP = ARCH_LEN'(4);

  state_t              state_q, state_d;
  logic [ARCH_LEN-1:0] pc_q, pc_d;
  // Set when the outstanding request belongs to a path that a redirect has
  // abandoned; its response must be thrown away.
  logic                drop_q, drop_d;
  logic [INST_LEN-1:0] inst_q, inst_d;
  logic [ARCH_LEN-1:0] inst_pc_q, inst_pc_d;

  // Redirect targets are word aligned.
  logic [ARCH_LEN-1:0] redirect_tgt;
  assign redirect_tgt = {redirect_pc_in[ARCH_LEN-1:2], 2'b00};

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= BOOT;
      pc_q      <= BOOT_ADDR;
      drop_q    <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      drop_q    <= drop_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  // Next-state logic. Redirect is checked first in every state, so it wins
  // over stall and over a same-cycle response.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;

    unique case (state_q)
      BOOT: begin
        if (redirect_valid_in) pc_d = redirect_tgt;
        state_d = REQ;
      end

      REQ: begin
        if (redirect_valid_in) begin
          pc_d = redirect_tgt;
          // If the old-path request is taken this very cycle, its response
          // still has to be consumed and discarded.
          if (mem_req_ready_in) begin
            drop_d  = 1'b1;
            state_d = WAIT;
          end
        end else if (mem_req_ready_in) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (redirect_valid_in) begin
          pc_d = redirect_tgt;
          if (mem_rsp_valid_in) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (mem_rsp_valid_in) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            inst_d    = mem_rsp_data_in;
            inst_pc_d = pc_q;
            pc_d      = pc_q + PC_STEP;   // wraps modulo 2^ARCH_LEN
            state_d   = HOLD;
          end
        end
      end

      HOLD: begin
        if (redirect_valid_in) begin
          pc_d    = redirect_tgt;
          state_d = REQ;
        end else if (!stall_in) begin
          state_d = REQ;
        end
      end

      default: state_d = BOOT;
    endcase
  end

  // Outputs are decoded from registered state only, so nothing here has a
  // combinational path from an input.
  assign mem_req_valid_out = (state_q == REQ);
  assign mem_req_addr_out  = pc_q;
  assign inst_valid_out    = (state_q == HOLD);
  assign inst_out          = inst_q;
  assign inst_pc_out       = inst_pc_q;
  assign state_dbg         = state_q;

endmodule
